// File: rtl/tv80_bridge_pkg.sv
// Shared types and constants for the TV80 CPU-to-bus bridge.
package tv80_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_DATA = 8'hFF;
    localparam int         CNT_W     = 8;

endpackage

// File: rtl/tv80_bridge_timer.sv
// Cycle counter for one bus access: reports wait-state completion and timeout.
module tv80_bridge_timer
    import tv80_bridge_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic done,
    output logic expired
);

    logic [CNT_W-1:0] cnt;
    logic             active;

    // cnt holds the number of full cycles spent in the request before the current one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            active <= 1'b1;
        end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (active && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done    = active && (int'(cnt) + 1 >= WAIT_STATES);
    assign expired = active && (int'(cnt) + 1 >= TIMEOUT);

endmodule

// File: rtl/tv80_bus_bridge.sv
// Bridges TV80 CPU strobes to a req/ack bus with wait-state and timeout control.
// Define TV80_BRIDGE_IO_EN to forward I/O cycles; otherwise they complete locally.
module tv80_bus_bridge
    import tv80_bridge_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic        wait_n,
    output logic [7:0]  di,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        err
);

`ifdef TV80_BRIDGE_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    state_t state;
    logic   acked;
    logic   ws_done, expired;
    logic   space, intack, is_io, access, fwd, proto_err, start, clear;

    always_comb begin
        space     = !mreq_n || !iorq_n;
        intack    = !m1_n && !iorq_n;
        is_io     = mreq_n && !iorq_n;
        access    = rfsh_n && space && (rd_n != wr_n) && !intack;
        fwd       = access && (IO_EN || !is_io);
        proto_err = rfsh_n && space && !rd_n && !wr_n;
        start     = (state == ST_IDLE) && fwd;
        clear     = (state != ST_REQ);
        wait_n    = !(start || state == ST_REQ);
    end

    tv80_bridge_timer #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .clear   (clear),
        .done    (ws_done),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            acked     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            di        <= IDLE_DATA;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acked <= 1'b0;
                    if (intack) begin
                        di    <= IDLE_DATA;
                        state <= ST_DONE;
                    end else if (proto_err) begin
                        err <= 1'b1;
                    end else if (fwd) begin
                        bus_req   <= 1'b1;
                        bus_addr  <= A;
                        bus_wdata <= dout;
                        bus_we    <= ~wr_n;
                        bus_io    <= IO_EN && is_io;
                        state     <= ST_REQ;
                    end else if (access) begin
                        // unforwarded I/O: reads float high, writes vanish
                        if (!rd_n) di <= IDLE_DATA;
                        state <= ST_DONE;
                    end
                end
                ST_REQ: begin
                    // an early ack is latched so the bus is freed while wait states run out
                    if (bus_ack && !acked) begin
                        acked   <= 1'b1;
                        bus_req <= 1'b0;
                        if (!bus_we) di <= bus_rdata;
                    end
                    if ((bus_ack || acked) && ws_done) begin
                        state <= ST_DONE;
                    end else if (!bus_ack && !acked && expired) begin
                        bus_req <= 1'b0;
                        di      <= IDLE_DATA;
                        err     <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rd_n && wr_n) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tv80_bus_bridge.md
TV80_BUS_BRIDGE -- requirements
Module: tv80_bus_bridge

Interface
REQ-001 Parameter WAIT_STATES, default 0: minimum number of clk cycles wait_n is held low per access, counted from bus_req assertion.
REQ-002 Parameter TIMEOUT, default 255: cycles without bus_ack before the access is forcibly completed (range 1..255).
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  CPU bus strobes, active low.
REQ-006 A  in  16  CPU address.
REQ-007 dout  in  8  CPU write data.
REQ-008 wait_n  out  1  wait request to CPU; low stretches the current T2.
REQ-009 di  out  8  read data to CPU, registered.
REQ-010 bus_req, bus_we, bus_io  out  1 each  request, write flag and I/O-space flag.
REQ-011 bus_addr  out  16; bus_wdata  out  8  request address and write data.
REQ-012 bus_ack  in  1; bus_rdata  in  8  completion strobe and read data, valid together.
REQ-013 err  out  1  sticky error flag.

Function
REQ-014 An access starts when the FSM is IDLE, rfsh_n=1, (mreq_n=0 or iorq_n=0) and exactly one of rd_n/wr_n is 0; refresh cycles are ignored.
REQ-015 FSM states: IDLE, REQ, DONE.
- IDLE->REQ on access start.
- REQ->DONE on completion.
- DONE->IDLE when rd_n=wr_n=1.
REQ-016 wait_n is combinational. It is 0 when IDLE with the start condition true, and 0 in REQ. It is 1 in all other cases.
REQ-017 On IDLE->REQ, bus_addr, bus_wdata, bus_we (=~wr_n) and bus_io (=~iorq_n) are registered, and bus_req is set. These are held stable until bus_ack is sampled high.
REQ-018 Completion occurs at the first cycle where bus_ack was sampled and WAIT_STATES cycles have elapsed since bus_req rose.
- bus_req clears the cycle after bus_ack is sampled.
- A read registers bus_rdata into di at the ack.
REQ-019 In DONE, di is held stable and wait_n=1 until the strobes release.
REQ-020 Timeout: in REQ, after TIMEOUT cycles with no ack, bus_req drops, di=8'hFF, err sets, and the FSM goes to DONE. If ack and timeout occur in the same cycle, ack wins and err is not set.
REQ-021 Interrupt acknowledge (m1_n=0, iorq_n=0) issues no bus request. di=8'hFF, and the FSM goes directly to DONE with wait_n=1.
REQ-022 rd_n=0 and wr_n=0 together with an active space strobe is a protocol error. err sets, no request is issued, and the FSM stays IDLE.
REQ-023 Strobes released while in REQ do not abort the request. The FSM completes the handshake, then returns to IDLE through DONE.
REQ-024 The FSM advances every clk, independent of CPU clock enable.

Reset
REQ-025 While reset_n=0:
- FSM=IDLE, bus_req=0, bus_we=0, bus_io=0.
- bus_addr=0, bus_wdata=0, di=8'hFF, err=0.
- Counters=0.
- wait_n follows REQ-016.
REQ-026 Reset asserted mid-access drops bus_req immediately. No partial data is retained.

Configuration
REQ-027 Macro TV80_BRIDGE_IO_EN defined: I/O cycles are forwarded with bus_io=1.
REQ-028 Macro TV80_BRIDGE_IO_EN undefined:
- I/O reads complete at once with di=8'hFF and wait_n=1.
- I/O writes are dropped.
- bus_io is tied 0.

Structure
REQ-029 Package tv80_bridge_pkg holds the FSM state enum, the idle data constant 8'hFF and counter widths.
REQ-030 Sub-module tv80_bridge_timer holds the wait-state and timeout counters, with start/clear inputs and done/expired outputs.

Verification
REQ-031 Memory read A=16'h1234, bus_ack after 3 cycles with bus_rdata=8'h5A -> bus_addr=16'h1234, bus_we=0, wait_n low 3 cycles, di=8'h5A, err=0.
REQ-032 Memory write A=16'h8000, dout=8'hC3, immediate ack, WAIT_STATES=2 -> bus_we=1, bus_wdata=8'hC3, wait_n low exactly 2 cycles.
REQ-033 Read with no ack, TIMEOUT=8 -> bus_req drops after 8 cycles, di=8'hFF, err=1 and stays 1.
REQ-034 m1_n=iorq_n=0 -> bus_req stays 0, di=8'hFF, wait_n=1. Refresh cycle with mreq_n=0, rfsh_n=0 -> no request.
REQ-035 I/O write to port 8'h10:
- With TV80_BRIDGE_IO_EN: bus_io=1, bus_addr[7:0]=8'h10.
- Without TV80_BRIDGE_IO_EN: no bus_req.
REQ-036 reset_n pulsed low during REQ -> bus_req=0 asynchronously, di=8'hFF, the next access proceeds normally.
